ex_muldiv_unit: RTL and testbench

- Iterative RV64M multiply/divide unit inside the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the decoded operands and funct3 held in ID/EX.
- Its busy output drives exe_is_waiting, which holds ID/EX (and upstream stages) until the result is ready.
- Hands one 64-bit result per M-type instruction to the EX result mux.

---
 rtl/ex_muldiv_if.sv | 25 ++
 rtl/ex_muldiv_unit.sv | 217 +++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// EX-stage handshake between the ID/EX operand register and the multiply/divide unit.
// The master drives the decoded instruction; the slave returns stall, done and result.
interface ex_muldiv_if #(
   parameter int XLEN = 64
);
   logic            start;
   logic [2:0]      funct3;
   logic            is_word;
   logic [XLEN-1:0] srca;
   logic [XLEN-1:0] srcb;
   logic            flush;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, funct3, is_word, srca, srcb, flush,
      input  busy, done, result
   );

   modport slave (
      input  start, funct3, is_word, srca, srcb, flush,
      output busy, done, result
   );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV64M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Define MULDIV_FASTMUL_EN for a single-cycle combinational multiplier (divide stays iterative).
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start; latches prepared operands and flags
// S_MUL  | shift-add iteration on operand magnitudes (iterative build only)
// S_DIV  | restoring division iteration on operand magnitudes
// S_DONE | result valid, done pulses, pipeline advances
module ex_muldiv_unit #(
   parameter int XLEN = 64,
   parameter int ITER = XLEN
) (
   input  logic         clk,
   input  logic         reset,
   ex_muldiv_if.slave   mdu
);

   localparam int CW = $clog2(ITER);
   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;
   logic [XLEN-1:0]   dvd_q, dvd_d;
   logic [1:0]        op_q, op_d;
   logic              word_q, word_d;
   logic              neg_res_q, neg_res_d;
   logic              neg_rem_q, neg_rem_d;
   logic              dz_q, dz_d;
   logic              ovf_q, ovf_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic              is_div, sgn_a, sgn_b, neg_a, neg_b, last_iter;
   logic [XLEN-1:0]   a_p, b_p, mag_a, mag_b;
   logic [XLEN:0]     div_tmp;
   logic              div_ge;
   logic [XLEN:0]     div_diff;
   logic [2*XLEN-1:0] div_next;
   logic [XLEN-1:0]   quo, rem, div_res;

   function automatic logic [XLEN-1:0] wfix(input logic w, input logic [XLEN-1:0] v);
      return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
   endfunction

   // Operand preparation: word ops extend the low halves before sign/magnitude split.
   always_comb begin
      is_div = mdu.funct3[2];
      sgn_a  = is_div ? ~mdu.funct3[0] : (mdu.funct3[1] ^ mdu.funct3[0]);
      sgn_b  = is_div ? ~mdu.funct3[0] : (mdu.funct3[1:0] == 2'b01);
      a_p    = mdu.srca;
      b_p    = mdu.srcb;
      if (mdu.is_word) begin
         a_p = sgn_a ? {{(XLEN-32){mdu.srca[31]}}, mdu.srca[31:0]}
                     : {{(XLEN-32){1'b0}}, mdu.srca[31:0]};
         b_p = sgn_b ? {{(XLEN-32){mdu.srcb[31]}}, mdu.srcb[31:0]}
                     : {{(XLEN-32){1'b0}}, mdu.srcb[31:0]};
      end
      neg_a  = sgn_a & a_p[XLEN-1];
      neg_b  = sgn_b & b_p[XLEN-1];
      mag_a  = neg_a ? -a_p : a_p;
      mag_b  = neg_b ? -b_p : b_p;
   end

   // acc holds {remainder, quotient-in-progress}; dividend bits shift out the top of the low half.
   always_comb begin
      div_tmp  = acc_q[2*XLEN-1:XLEN-1];
      div_ge   = (div_tmp >= {1'b0, opnd_q});
      div_diff = div_tmp - {1'b0, opnd_q};
      div_next = {(div_ge ? div_diff[XLEN-1:0] : div_tmp[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
      quo      = neg_res_q ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
      rem      = neg_rem_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
      if (dz_q) begin
         quo = '1;
         rem = dvd_q;
      end else if (ovf_q) begin
         quo = MIN_VAL;
         rem = '0;
      end
      div_res = wfix(word_q, op_q[1] ? rem : quo);
   end

`ifdef MULDIV_FASTMUL_EN
   logic signed [2*XLEN+1:0] fast_prod;
   logic [XLEN-1:0]          fast_res;

   always_comb begin
      fast_prod = $signed({sgn_a & a_p[XLEN-1], a_p}) * $signed({sgn_b & b_p[XLEN-1], b_p});
      fast_res  = wfix(mdu.is_word, (mdu.funct3[1:0] == 2'b00) ? fast_prod[XLEN-1:0]
                                                              : fast_prod[2*XLEN-1:XLEN]);
   end
`else
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next, mul_prod;
   logic [XLEN-1:0]   mul_res;

   // acc holds {partial high, multiplier remainder}; the product fills in from the top.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next = {mul_sum, acc_q[XLEN-1:1]};
      mul_prod = neg_res_q ? -mul_next : mul_next;
      mul_res  = wfix(word_q, (op_q == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN]);
   end
`endif

   assign last_iter = (cnt_q == CW'(ITER-1));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      dvd_d     = dvd_q;
      op_d      = op_q;
      word_d    = word_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;
      ovf_d     = ovf_q;
      result_d  = result_q;
      if (mdu.flush) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (mdu.start) begin
                  cnt_d     = '0;
                  op_d      = mdu.funct3[1:0];
                  word_d    = mdu.is_word;
                  dvd_d     = a_p;
                  dz_d      = (b_p == '0);
                  ovf_d     = is_div & sgn_a & (a_p == MIN_VAL) & (b_p == '1);
                  neg_res_d = neg_a ^ neg_b;
                  neg_rem_d = neg_a;
                  if (is_div) begin
                     state_d = S_DIV;
                     acc_d   = {{XLEN{1'b0}}, mag_a};
                     opnd_d  = mag_b;
                  end else begin
`ifdef MULDIV_FASTMUL_EN
                     state_d  = S_DONE;
                     result_d = fast_res;
`else
                     state_d  = S_MUL;
                     acc_d    = {{XLEN{1'b0}}, mag_b};
                     opnd_d   = mag_a;
`endif
                  end
               end
            end
`ifndef MULDIV_FASTMUL_EN
            S_MUL: begin
               acc_d = mul_next;
               cnt_d = cnt_q + CW'(1);
               if (last_iter) begin
                  state_d  = S_DONE;
                  cnt_d    = '0;
                  result_d = mul_res;
               end
            end
`endif
            S_DIV: begin
               acc_d = div_next;
               cnt_d = cnt_q + CW'(1);
               if (last_iter) begin
                  state_d  = S_DONE;
                  cnt_d    = '0;
                  result_d = div_res;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         dvd_q     <= '0;
         op_q      <= '0;
         word_q    <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         ovf_q     <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         dvd_q     <= dvd_d;
         op_q      <= op_d;
         word_q    <= word_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
         ovf_q     <= ovf_d;
         result_q  <= result_d;
      end
   end

   // A flush arriving in the DONE cycle kills the result before the pipeline takes it.
   assign mdu.busy   = (state_q == S_MUL) || (state_q == S_DIV) ||
                       ((state_q == S_IDLE) && mdu.start && !mdu.flush);
   assign mdu.done   = (state_q == S_DONE) && !mdu.flush;
   assign mdu.result = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: hand-computed RV64M results, latency, flush and reset.
module tb_ex_muldiv_unit;

`ifdef MULDIV_FASTMUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 65;
`endif
   localparam int DIV_LAT = 65;

   logic clk;
   logic reset;
   int   total;
   int   passes;
   int   fails;

   ex_muldiv_if mdu_if ();

   ex_muldiv_unit dut (
      .clk   (clk),
      .reset (reset),
      .mdu   (mdu_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] f3, input logic w,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input int exp_lat);
      int lat;
      int busy_cnt;
      @(negedge clk);
      mdu_if.funct3  = f3;
      mdu_if.is_word = w;
      mdu_if.srca    = a;
      mdu_if.srcb    = b;
      mdu_if.start   = 1'b1;
      #1;
      chk({tag, "_busy_first"}, 64'(mdu_if.busy), 64'd1);
      lat      = 0;
      busy_cnt = 1;
      while (mdu_if.done !== 1'b1 && lat < 200) begin
         @(negedge clk);
         lat++;
         if (mdu_if.busy === 1'b1) busy_cnt++;
      end
      chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_result"}, mdu_if.result, exp);
      chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
      mdu_if.start = 1'b0;
   endtask

   initial begin
      int   n;
      logic seen;
      total  = 0;
      passes = 0;
      fails  = 0;
      reset          = 1'b0;
      mdu_if.start   = 1'b0;
      mdu_if.funct3  = 3'b000;
      mdu_if.is_word = 1'b0;
      mdu_if.srca    = '0;
      mdu_if.srcb    = '0;
      mdu_if.flush   = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_busy", 64'(mdu_if.busy), 64'd0);
      chk("reset_done", 64'(mdu_if.done), 64'd0);
      chk("reset_result", mdu_if.result, 64'd0);
      reset = 1'b1;
      @(negedge clk);

      run_op("mul",    3'b000, 1'b0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, MUL_LAT);
      run_op("mulhu",  3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, MUL_LAT);
      run_op("mulh",   3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, MUL_LAT);
      run_op("mulhsu", 3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, MUL_LAT);
      run_op("mulw",   3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, MUL_LAT);
      run_op("div_ovf", 3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
             64'h8000_0000_0000_0000, DIV_LAT);
      run_op("rem_ovf", 3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
             64'd0, DIV_LAT);
      run_op("div_neg", 3'b100, 1'b0, -64'sd7, 64'd2, -64'sd3, DIV_LAT);
      run_op("rem_neg", 3'b110, 1'b0, -64'sd7, 64'd2, -64'sd1, DIV_LAT);
      run_op("divu_dz", 3'b101, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, DIV_LAT);
      run_op("remw_dz", 3'b110, 1'b1, 64'h0000_0001_8000_0005, 64'd0,
             64'hFFFF_FFFF_8000_0005, DIV_LAT);
      run_op("divw",   3'b100, 1'b1, -64'sd20, 64'd6, -64'sd3, DIV_LAT);
      run_op("remuw",  3'b111, 1'b1, 64'hFFFF_FFFF, 64'h10, 64'hF, DIV_LAT);
      run_op("divuw",  3'b101, 1'b1, 64'hFFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, DIV_LAT);

      // start together with flush must not launch anything
      @(negedge clk);
      mdu_if.funct3 = 3'b100;
      mdu_if.srca   = 64'd50;
      mdu_if.srcb   = 64'd5;
      mdu_if.start  = 1'b1;
      mdu_if.flush  = 1'b1;
      #1;
      chk("flush_vs_start_busy", 64'(mdu_if.busy), 64'd0);
      @(negedge clk);
      mdu_if.start = 1'b0;
      mdu_if.flush = 1'b0;
      #1;
      chk("flush_vs_start_idle", 64'(mdu_if.busy), 64'd0);

      // flush at T+10 of a divide
      @(negedge clk);
      mdu_if.funct3  = 3'b100;
      mdu_if.is_word = 1'b0;
      mdu_if.srca    = 64'd1000;
      mdu_if.srcb    = 64'd7;
      mdu_if.start   = 1'b1;
      for (n = 1; n <= 10; n++) @(negedge clk);
      chk("flush_busy_before", 64'(mdu_if.busy), 64'd1);
      mdu_if.flush = 1'b1;
      @(negedge clk);
      mdu_if.flush = 1'b0;
      mdu_if.start = 1'b0;
      #1;
      chk("flush_busy_after", 64'(mdu_if.busy), 64'd0);
      seen = 1'b0;
      for (n = 0; n < 80; n++) begin
         @(negedge clk);
         if (mdu_if.done === 1'b1 || mdu_if.busy === 1'b1) seen = 1'b1;
      end
      chk("flush_no_done", 64'(seen), 64'd0);

      // reset at T+30 of a multiply; result currently holds the DIVUW value
      @(negedge clk);
      mdu_if.funct3  = 3'b000;
      mdu_if.srca    = 64'd7;
      mdu_if.srcb    = 64'd9;
      mdu_if.start   = 1'b1;
      for (n = 1; n <= 30; n++) @(negedge clk);
      reset        = 1'b0;
      mdu_if.start = 1'b0;
      @(negedge clk);
      chk("midrst_busy", 64'(mdu_if.busy), 64'd0);
      chk("midrst_done", 64'(mdu_if.done), 64'd0);
      chk("midrst_result", mdu_if.result, 64'd0);
      reset = 1'b1;

      run_op("divu_after_rst", 3'b101, 1'b0, 64'd9, 64'd2, 64'd4, DIV_LAT);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
